// File: rtl/pulse_monitor_if.sv
// -----------------------------------------------------------------------------
// pulse_monitor_if
//
// Purpose : groups the measurement-side signals of pulse_monitor so that the
//           monitor and whatever drives/observes it share one bundle. clk and
//           rst stay plain ports on the module itself.
//
// Parameters:
//   CNT_W       width of the duration/period measurement outputs
//
// Signals:
//   i_pulse     pulse train under measurement (driven by master)
//   i_clr       clears o_err, the lock count and o_err_cnt (driven by master)
//   o_valid     one-cycle strobe: new o_duration/o_period
//   o_duration  last measured high time, in cycles
//   o_period    last measured rise-to-rise period, in cycles
//   o_err       sticky mismatch / stuck-input flag
//   o_locked    enough consecutive matching measurements seen
//   o_err_cnt   saturating error event count (only with
//               PULSE_MONITOR_ERR_CNT_EN defined)
//
// Modports:
//   master      the side that drives the pulse train and observes results
//   slave       the pulse_monitor itself
// -----------------------------------------------------------------------------
interface pulse_monitor_if #(
  parameter int CNT_W = 8
);

  logic             i_pulse;
  logic             i_clr;
  logic             o_valid;
  logic [CNT_W-1:0] o_duration;
  logic [CNT_W-1:0] o_period;
  logic             o_err;
  logic             o_locked;
`ifdef PULSE_MONITOR_ERR_CNT_EN
  logic [7:0]       o_err_cnt;
`endif

`ifdef PULSE_MONITOR_ERR_CNT_EN
  modport master (
    output i_pulse, i_clr,
    input  o_valid, o_duration, o_period, o_err, o_locked, o_err_cnt
  );

  modport slave (
    input  i_pulse, i_clr,
    output o_valid, o_duration, o_period, o_err, o_locked, o_err_cnt
  );
`else
  modport master (
    output i_pulse, i_clr,
    input  o_valid, o_duration, o_period, o_err, o_locked
  );

  modport slave (
    input  i_pulse, i_clr,
    output o_valid, o_duration, o_period, o_err, o_locked
  );
`endif

endinterface : pulse_monitor_if

// File: rtl/pulse_monitor.sv
// -----------------------------------------------------------------------------
// pulse_monitor
//
// Purpose : measures the high time and rise-to-rise period of a synchronous
//           pulse train, compares each measurement against the expected
//           values and reports lock / error status.
//
//           A measurement is taken on every rising edge of i_pulse seen from
//           the LOW state; the very first rise after reset or after a stuck
//           condition only arms the measurement and produces no strobe.
//           If the period counter saturates without a new rise (input stuck
//           high or low) the monitor returns to IDLE and flags an error.
//
// Parameters:
//   EXP_DURATION  expected high time in cycles       (1 .. 2^CNT_W-2)
//   EXP_PERIOD    expected rise-to-rise period        (EXP_DURATION+1 .. 2^CNT_W-1)
//   CNT_W         width of counters and measurement outputs
//   LOCK_CNT      consecutive matches needed for lock (1 .. 255)
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous, active-low reset
//   bus           pulse_monitor_if.slave (i_pulse, i_clr in; o_valid,
//                 o_duration, o_period, o_err, o_locked[, o_err_cnt] out)
//
// Configuration:
//   PULSE_MONITOR_ERR_CNT_EN  when defined, adds the 8-bit saturating
//                             o_err_cnt output and its counter.
// -----------------------------------------------------------------------------
module pulse_monitor #(
  parameter int EXP_DURATION = 2,
  parameter int EXP_PERIOD   = 3,
  parameter int CNT_W        = 8,
  parameter int LOCK_CNT     = 4
) (
  input  logic          clk,
  input  logic          rst,
  pulse_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXP_DUR_C = CNT_W'(EXP_DURATION);
  localparam logic [CNT_W-1:0] EXP_PER_C = CNT_W'(EXP_PERIOD);
  localparam logic [7:0]       LOCK_TGT  = 8'(LOCK_CNT);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             p_q;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [7:0]       lock_q, lock_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             err_q, err_d;

  // ---------------------------------------------------------------------------
  // Edge detection and event decode
  // ---------------------------------------------------------------------------
  logic rise;
  logic fall;
  logic meas;       // rise from LOW: a complete period has been observed
  logic stuck;      // period counter saturated with no rise in sight
  logic match;      // measurement about to be published equals expectation
  logic err_event;  // mismatch or stuck on this edge

  assign rise  = bus.i_pulse & ~p_q;
  assign fall  = ~bus.i_pulse & p_q;
  assign meas  = (state_q == LOW) && rise;
  // The period counter is allowed to hold CNT_MAX for one cycle so that a
  // period of exactly 2^CNT_W-1 is still measurable; only a missing rise on
  // the following edge is treated as a stuck input.
  assign stuck = (state_q != IDLE) && !rise && (per_cnt_q == CNT_MAX);
  // The counters hold exactly the values that will be published on a
  // measurement edge, so the comparison is done on them directly.
  assign match     = (hi_cnt_q == EXP_DUR_C) && (per_cnt_q == EXP_PER_C);
  assign err_event = (meas && !match) || stuck;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in a combinational block gets a default
  // first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (stuck)     state_d = IDLE;
        else if (fall) state_d = LOW;
      end
      LOW: begin
        if (rise)       state_d = HIGH;
        else if (stuck) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    valid_d   = 1'b0;
    dur_d     = dur_q;
    period_d  = period_q;
    lock_d    = lock_q;
    err_d     = err_q;

    // Measurement counters: a rise restarts both, otherwise they run while a
    // measurement is armed. i_clr deliberately has no influence here.
    if (rise) begin
      per_cnt_d = CNT_ONE;
      hi_cnt_d  = CNT_ONE;
    end else if ((state_q != IDLE) && !stuck) begin
      per_cnt_d = per_cnt_q + CNT_ONE;
      if (bus.i_pulse) hi_cnt_d = hi_cnt_q + CNT_ONE;
    end

    // Publish the completed measurement on the rise that ends the period.
    if (meas) begin
      valid_d  = 1'b1;
      dur_d    = hi_cnt_q;
      period_d = per_cnt_q;
    end

    // Lock count: any error or a clear empties it; a match climbs toward
    // LOCK_TGT and stays there.
    if (err_event || bus.i_clr) begin
      lock_d = 8'd0;
    end else if (meas && (lock_q < LOCK_TGT)) begin
      lock_d = lock_q + 8'd1;
    end

    // Sticky error: a simultaneous event beats the clear.
    if (err_event) begin
      err_d = 1'b1;
    end else if (bus.i_clr) begin
      err_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_q       <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      lock_q    <= 8'd0;
      valid_q   <= 1'b0;
      dur_q     <= '0;
      period_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      p_q       <= bus.i_pulse;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      lock_q    <= lock_d;
      valid_q   <= valid_d;
      dur_q     <= dur_d;
      period_q  <= period_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_duration = dur_q;
  assign bus.o_period   = period_q;
  assign bus.o_err      = err_q;
  assign bus.o_locked   = (lock_q == LOCK_TGT);

`ifdef PULSE_MONITOR_ERR_CNT_EN
  // ---------------------------------------------------------------------------
  // Optional saturating error event counter
  // ---------------------------------------------------------------------------
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.i_clr) begin
      // A clear coinciding with an event still records that event.
      err_cnt_d = {7'd0, err_event};
    end else if (err_event && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.o_err_cnt = err_cnt_q;
`endif

endmodule : pulse_monitor

// File: doc/pulse_monitor.md
PULSE_MONITOR -- requirements
Module: pulse_monitor

Interface
REQ-001 SHALL have parameter EXP_DURATION, default 2, expected high time of i_pulse in clock cycles (1 to 2^CNT_W-2).
REQ-002 SHALL have parameter EXP_PERIOD, default 3, expected rise-to-rise period in clock cycles (EXP_DURATION+1 to 2^CNT_W-1).
REQ-003 SHALL have parameter CNT_W, default 8, width of all measurement counters and outputs.
REQ-004 SHALL have parameter LOCK_CNT, default 4, number of consecutive matching periods required for lock (1 to 255).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port i_pulse  input  1  pulse train under measurement, synchronous to clk.
REQ-008 SHALL have port i_clr  input  1  clears o_err, the lock count and o_err_cnt.
REQ-009 SHALL have port o_valid  output  1  one-cycle strobe: new measurement on o_duration/o_period.
REQ-010 SHALL have port o_duration  output  CNT_W  last measured high time, in cycles.
REQ-011 SHALL have port o_period  output  CNT_W  last measured period, in cycles.
REQ-012 SHALL have port o_err  output  1  sticky flag: mismatch or stuck input.
REQ-013 SHALL have port o_locked  output  1  LOCK_CNT consecutive matching measurements seen.

Function
REQ-014 SHALL register i_pulse into p_q each cycle; rise = i_pulse & ~p_q, fall = ~i_pulse & p_q, both evaluated on the same edge.
REQ-015 SHALL implement states IDLE, HIGH, LOW; IDLE waits for rise; HIGH moves to LOW on fall; LOW moves to HIGH on rise.
REQ-016 SHALL, on rise in any state, load per_cnt=1 and hi_cnt=1.
REQ-017 SHALL, in HIGH or LOW without rise, increment per_cnt, and increment hi_cnt while i_pulse=1.
REQ-018 SHALL, on rise in LOW, register o_period=per_cnt and o_duration=hi_cnt and pulse o_valid high for exactly one cycle (outputs update on the rise-sampling edge).
REQ-019 SHALL NOT assert o_valid on a rise taken from IDLE (first edge after reset or stuck recovery).
REQ-020 SHALL treat a measurement as matching when o_duration==EXP_DURATION and o_period==EXP_PERIOD, else mismatch.
REQ-021 SHALL, on mismatch, set o_err and zero the lock count, deasserting o_locked on the same edge as o_valid.
REQ-022 SHALL, on match, increment the lock count (saturating at LOCK_CNT) and assert o_locked once count==LOCK_CNT.
REQ-023 SHALL, when per_cnt reaches 2^CNT_W-1 without a rise (constant high or constant low input), go to IDLE, set o_err, zero the lock count; no o_valid.
REQ-024 SHALL hold o_duration/o_period between strobes.
REQ-025 SHALL, on i_clr, clear o_err and the lock count; if a mismatch or stuck event occurs on the same edge, o_err SHALL be set (set wins) and the count SHALL be zero.
REQ-026 SHALL NOT let i_clr affect the state machine, counters or measurement outputs.

Reset
REQ-027 SHALL, when rst=0 at a clock edge, set state=IDLE, p_q=0, per_cnt=0, hi_cnt=0, lock count=0, o_valid=0, o_duration=0, o_period=0, o_err=0, o_locked=0 (o_err_cnt=0 if present).
REQ-028 SHALL, for a rst asserted mid-measurement, discard the partial measurement; since p_q=0, an i_pulse already high on the first post-reset edge counts as a rise from IDLE.

Configuration
REQ-029 SHALL, with macro PULSE_MONITOR_ERR_CNT_EN defined, add port o_err_cnt  output  8  count of mismatch plus stuck events, saturating at 255, cleared by i_clr (clr with simultaneous event gives 1).
REQ-030 SHALL, without PULSE_MONITOR_ERR_CNT_EN, omit o_err_cnt and its logic entirely; all other behaviour is identical.

Verification
REQ-031 SHALL cover: defaults, i_pulse=1,1,0 repeating from reset release -> first o_valid at cycle 3 with duration 2 and period 3, o_locked high on 4th strobe, o_err=0.
REQ-032 SHALL cover: locked defaults, then one period of 1,1,1,0 -> o_valid with duration 3 and period 4, o_err=1 and o_locked=0 on the same edge, relock after 4 good periods, o_err stays 1.
REQ-033 SHALL cover: CNT_W=4, i_pulse held 1 for 20 cycles -> o_err=1 at per_cnt=15, state IDLE, no o_valid; next 1,1,0 train gives first strobe only after the second rise.
REQ-034 SHALL cover: i_clr asserted on the same edge as a mismatch strobe -> o_err=1, lock count 0; i_clr alone next cycle -> o_err=0.
REQ-035 SHALL cover: rst=0 for 1 cycle mid-LOW -> all outputs 0 next edge, no strobe for the interrupted period.
REQ-036 SHALL cover: PULSE_MONITOR_ERR_CNT_EN defined, 300 mismatching periods -> o_err_cnt=255; i_clr -> 0.
